addsub_result_reader: RTL

ADDSUB_RESULT_READER -- requirements
Module: addsub_result_reader

---
 rtl/addsub_result_reader.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/addsub_result_reader.sv
// Buffers {Sum, Sub} result pairs from an addsub in a small FIFO and serialises each pair as two tagged beats.
// Optional feature: define ADDSUB_READER_DROP_CNT_EN to add an 8-bit saturating drop_cnt output.
module addsub_result_reader #(
   parameter int N     = 4,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   input  logic signed [N:0]        Sum,
   input  logic signed [N:0]        Sub,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic signed [N:0]        out_data,
   output logic                     out_tag,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty
`ifdef ADDSUB_READER_DROP_CNT_EN
   ,
   output logic [7:0]               drop_cnt
`endif
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam int EW = 2 * (N + 1);

   typedef enum logic [1:0] {
      IDLE,
      BEAT_SUM,
      BEAT_SUB
   } state_t;

   state_t          state_q, state_d;
   logic [AW-1:0]   wrPtr_q, wrPtr_d;
   logic [AW-1:0]   rdPtr_q, rdPtr_d;
   logic [CW-1:0]   count_q, count_d;
   logic            full_q, full_d;
   logic            empty_q, empty_d;
   logic [EW-1:0]   mem_q [DEPTH];
   logic [EW-1:0]   headEntry;
   logic            push;
   logic            pop;

   // The pair is popped only when its second (Sub) beat is accepted.
   assign pop  = (state_q == BEAT_SUB) && out_ready && !rst;
   assign push = in_valid && (!full_q || pop) && !rst;

   assign headEntry = mem_q[rdPtr_q];

   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wrPtr_q] <= {Sum, Sub};
      end
   end

   always_comb begin
      wrPtr_d = wrPtr_q + AW'(push);
      rdPtr_d = rdPtr_q + AW'(pop);
      count_d = count_q + CW'(push) - CW'(pop);
      full_d  = (count_d == CW'(DEPTH));
      empty_d = (count_d == '0);
   end

   always_comb begin
      state_d   = state_q;
      out_valid = 1'b0;
      out_data  = '0;
      out_tag   = 1'b0;
      case (state_q)
         IDLE: begin
            if (!empty_q) begin
               state_d = BEAT_SUM;
            end
         end
         BEAT_SUM: begin
            out_valid = 1'b1;
            out_data  = headEntry[EW-1:N+1];
            if (out_ready) begin
               state_d = BEAT_SUB;
            end
         end
         BEAT_SUB: begin
            out_valid = 1'b1;
            out_data  = headEntry[N:0];
            out_tag   = 1'b1;
            if (out_ready) begin
               state_d = (count_q > CW'(1)) ? BEAT_SUM : IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         wrPtr_q <= '0;
         rdPtr_q <= '0;
         count_q <= '0;
         full_q  <= 1'b0;
         empty_q <= 1'b1;
      end else begin
         state_q <= state_d;
         wrPtr_q <= wrPtr_d;
         rdPtr_q <= rdPtr_d;
         count_q <= count_d;
         full_q  <= full_d;
         empty_q <= empty_d;
      end
   end

   assign count = count_q;
   assign full  = full_q;
   assign empty = empty_q;

`ifdef ADDSUB_READER_DROP_CNT_EN
   logic [7:0] dropCnt_q, dropCnt_d;
   logic       drop;

   assign drop = in_valid && full_q && !pop && !rst;

   always_comb begin
      dropCnt_d = dropCnt_q;
      if (drop && (dropCnt_q != 8'hFF)) begin
         dropCnt_d = dropCnt_q + 8'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         dropCnt_q <= '0;
      end else begin
         dropCnt_q <= dropCnt_d;
      end
   end

   assign drop_cnt = dropCnt_q;
`endif

endmodule
